stageex_mdu: RTL and testbench

Parametrised execute-stage multiply/divide unit for the pipelined RV32 core, sitting in EX beside the ALU and branch comparator. It adds the RV32M operations with the same operand-forwarding selection as the ALU path, a single-cycle registered multiplier and an iterative radix-2^DIV_BITS divider. A stall handshake holds IF/ID/EX while an operation is in flight, and a flush input aborts it when a control hazard redirects the PC.

---
 rtl/stageex_mdu.sv | 231 +++++++++++++++++++++++
 tb/tb_stageex_mdu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stageex_mdu.sv
// -----------------------------------------------------------------------------
// stageex_mdu -- execute-stage RV32M multiply/divide unit.
//
// Multiplies finish in one cycle through a registered full-width product.
// Divides use an iterative restoring divider that retires DIV_BITS quotient
// bits per cycle. The divide-by-zero and signed-overflow cases finish in one
// cycle. o_busy stalls IF/ID/EX while an operation is being accepted or
// iterated. i_flush aborts whatever is in flight.
//
// Ports:
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   i_valid, i_fun3           M-extension instruction present in EX, funct3
//   i_fwd_a_sel, i_fwd_b_sel  operand forwarding selects (01 MEM, 10 WB, else RF)
//   i_rs1_data, i_rs2_data    register-file operands
//   i_fwd_mem_data            MEM-stage forwarding source
//   i_fwd_wb_data             WB-stage forwarding source
//   i_flush                   control-hazard abort
//   o_busy                    stall request (combinational)
//   o_valid                   result valid; the instruction leaves EX
//   o_result                  registered result
// -----------------------------------------------------------------------------
module stageex_mdu #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [2:0]      i_fun3,
    input  logic [1:0]      i_fwd_a_sel,
    input  logic [1:0]      i_fwd_b_sel,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_fwd_mem_data,
    input  logic [XLEN-1:0] i_fwd_wb_data,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);

    localparam int N_ITER = XLEN / DIV_BITS;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [XLEN-1:0]  ZERO_VAL = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONE_VAL  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ONES_VAL = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Forwarding select: 01 MEM, 10 WB, 00/11 register file.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] mem,
                                                input logic [XLEN-1:0] wb);
        case (sel)
            2'b01:   fwd_mux = mem;
            2'b10:   fwd_mux = wb;
            default: fwd_mux = rf;
        endcase
    endfunction

    // Two's-complement negation; MIN maps to itself and is then read as an unsigned magnitude.
    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        negate = ~x + ONE_VAL;
    endfunction

    // One restoring step: shift the next dividend bit into the partial remainder and subtract if it fits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0]   trial;
        logic [XLEN-1:0] q;
        trial = {rem, quo[XLEN-1]};
        q     = {quo[XLEN-2:0], 1'b0};
        if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            q[0]  = 1'b1;
        end else begin
            q[0]  = 1'b0;
        end
        div_step = {trial[XLEN-1:0], q};
    endfunction

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   rem_r, quo_r, div_r;
    logic              neg_q_r, neg_r_r, sel_rem_r;

    logic [XLEN-1:0]   op_a_s, op_b_s, abs_a_s, abs_b_s;
    logic              accept_s, a_neg_s, b_neg_s, b_zero_s, div_ovf_s, one_cycle_s;
    logic [2*XLEN-1:0] mul_a_s, mul_b_s, prod_s, step_s;
    logic [XLEN-1:0]   fast_res_s, div_res_s, rem_nx_s, quo_nx_s;

    assign op_a_s   = fwd_mux(i_fwd_a_sel, i_rs1_data, i_fwd_mem_data, i_fwd_wb_data);
    assign op_b_s   = fwd_mux(i_fwd_b_sel, i_rs2_data, i_fwd_mem_data, i_fwd_wb_data);
    assign accept_s = (state_r == ST_IDLE) & i_valid & ~i_flush;

    // funct3[0]==0 marks the signed divide ops (DIV, REM).
    assign a_neg_s     = ~i_fun3[0] & op_a_s[XLEN-1];
    assign b_neg_s     = ~i_fun3[0] & op_b_s[XLEN-1];
    assign abs_a_s     = a_neg_s ? negate(op_a_s) : op_a_s;
    assign abs_b_s     = b_neg_s ? negate(op_b_s) : op_b_s;
    assign b_zero_s    = (op_b_s == ZERO_VAL);
    assign div_ovf_s   = ~i_fun3[0] & (op_a_s == MIN_VAL) & (op_b_s == ONES_VAL);
    assign one_cycle_s = ~i_fun3[2] | b_zero_s | div_ovf_s;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH; the product wraps at 2*XLEN bits.
    assign mul_a_s = {{XLEN{(i_fun3[1] ^ i_fun3[0]) & op_a_s[XLEN-1]}}, op_a_s};
    assign mul_b_s = {{XLEN{~i_fun3[1] & i_fun3[0] & op_b_s[XLEN-1]}}, op_b_s};
    assign prod_s  = mul_a_s * mul_b_s;

    // Result for every operation that completes in the accept cycle.
    always_comb begin
        fast_res_s = ZERO_VAL;
        if (~i_fun3[2]) begin
            fast_res_s = (i_fun3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end else if (b_zero_s) begin
            fast_res_s = i_fun3[1] ? op_a_s : ONES_VAL;
        end else if (div_ovf_s) begin
            fast_res_s = i_fun3[1] ? ZERO_VAL : MIN_VAL;
        end else begin
            fast_res_s = ZERO_VAL;
        end
    end

    // DIV_BITS restoring steps chained within one cycle.
    always_comb begin
        step_s = {rem_r, quo_r};
        for (int i = 0; i < DIV_BITS; i++) begin
            step_s = div_step(step_s[2*XLEN-1:XLEN], step_s[XLEN-1:0], div_r);
        end
    end

    assign rem_nx_s  = step_s[2*XLEN-1:XLEN];
    assign quo_nx_s  = step_s[XLEN-1:0];
    assign div_res_s = sel_rem_r ? (neg_r_r ? negate(rem_nx_s) : rem_nx_s)
                                 : (neg_q_r ? negate(quo_nx_s) : quo_nx_s);

    // Next-state logic; a flush always returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = one_cycle_s ? ST_DONE : ST_DIV;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
        if (i_flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, divider iteration and result register; a flush only clears the counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r     <= CNT_ZERO;
            rem_r     <= ZERO_VAL;
            quo_r     <= ZERO_VAL;
            div_r     <= ZERO_VAL;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            sel_rem_r <= 1'b0;
            o_result  <= ZERO_VAL;
        end else if (i_flush) begin
            cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && one_cycle_s) begin
                        o_result <= fast_res_s;
                    end else if (accept_s) begin
                        rem_r     <= ZERO_VAL;
                        quo_r     <= abs_a_s;
                        div_r     <= abs_b_s;
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_r_r   <= a_neg_s;
                        sel_rem_r <= i_fun3[1];
                        cnt_r     <= CNT_INIT;
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        o_result <= div_res_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign o_busy  = i_rst_n & (accept_s | (state_r == ST_DIV));
    // A flush in DONE withdraws the completing result in that same cycle.
    assign o_valid = (state_r == ST_DONE) & ~i_flush;

endmodule

// File: tb/tb_stageex_mdu.sv
module tb_stageex_mdu;

    localparam logic [31:0] MIN32  = 32'h8000_0000;
    localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_flush;
    logic [2:0]  i_fun3;
    logic [1:0]  asel, bsel;
    logic [31:0] rs1, rs2, mem_d, wb_d;
    logic [2:0]  busy_v, valid_v;
    logic [31:0] res_v [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stageex_mdu #(.XLEN(32), .DIV_BITS(1)) u_mdu1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_fun3(i_fun3),
        .i_fwd_a_sel(asel), .i_fwd_b_sel(bsel), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .i_fwd_mem_data(mem_d), .i_fwd_wb_data(wb_d), .i_flush(i_flush),
        .o_busy(busy_v[0]), .o_valid(valid_v[0]), .o_result(res_v[0]));

    stageex_mdu #(.XLEN(32), .DIV_BITS(2)) u_mdu2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_fun3(i_fun3),
        .i_fwd_a_sel(asel), .i_fwd_b_sel(bsel), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .i_fwd_mem_data(mem_d), .i_fwd_wb_data(wb_d), .i_flush(i_flush),
        .o_busy(busy_v[1]), .o_valid(valid_v[1]), .o_result(res_v[1]));

    stageex_mdu #(.XLEN(32), .DIV_BITS(4)) u_mdu4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_fun3(i_fun3),
        .i_fwd_a_sel(asel), .i_fwd_b_sel(bsel), .i_rs1_data(rs1), .i_rs2_data(rs2),
        .i_fwd_mem_data(mem_d), .i_fwd_wb_data(wb_d), .i_flush(i_flush),
        .o_busy(busy_v[2]), .o_valid(valid_v[2]), .o_result(res_v[2]));

    typedef struct {
        logic [2:0]  fun3;
        logic [31:0] rs1, rs2;
        logic [1:0]  asel, bsel;
        logic [31:0] mem, wb, exp;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] m, input logic [31:0] w);
        if (sel == 2'b01) return m;
        if (sel == 2'b10) return w;
        return rf;
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return ONES32;
                if (a == MIN32 && b == ONES32) return MIN32;
                return ia / ib;
            end
            3'd5: return (b == 32'h0) ? ONES32 : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == MIN32 && b == ONES32) return 32'h0;
                return ia % ib;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int db);
        if (!f[2] || b == 32'h0 || (!f[0] && a == MIN32 && b == ONES32)) return 1;
        return 32 / db + 1;
    endfunction

    // Issue one operation and follow all three instances until each has completed.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [1:0] sa, input logic [1:0] sb, input logic [31:0] m,
                          input logic [31:0] w, input logic [31:0] exp);
        int lat [3];
        int dbs [3];
        logic [31:0] ea, eb;
        dbs[0] = 1; dbs[1] = 2; dbs[2] = 4;
        ea = ref_fwd(sa, r1, m, w);
        eb = ref_fwd(sb, r2, m, w);
        for (int j = 0; j < 3; j++) lat[j] = ref_lat(f, ea, eb, dbs[j]);
        @(negedge clk);
        i_valid = 1'b1; i_fun3 = f; asel = sa; bsel = sb;
        rs1 = r1; rs2 = r2; mem_d = m; wb_d = w;
        #1;
        chk({tag, "/busy_at_accept"}, {29'h0, busy_v}, 32'h7);
        chk({tag, "/valid_at_accept"}, {29'h0, valid_v}, 32'h0);
        for (int k = 1; k <= lat[0]; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            rs1 = $urandom; rs2 = $urandom; mem_d = $urandom; wb_d = $urandom;
            asel = 2'($urandom_range(0, 3)); bsel = 2'($urandom_range(0, 3));
            #1;
            for (int j = 0; j < 3; j++) begin
                if (k < lat[j]) begin
                    chk($sformatf("%s/db%0d/t%0d_valid_busy", tag, dbs[j], k),
                        {30'h0, valid_v[j], busy_v[j]}, 32'h1);
                end else if (k == lat[j]) begin
                    chk($sformatf("%s/db%0d/t%0d_valid_busy", tag, dbs[j], k),
                        {30'h0, valid_v[j], busy_v[j]}, 32'h2);
                    chk($sformatf("%s/db%0d/result", tag, dbs[j]), res_v[j], exp);
                end else begin
                    chk($sformatf("%s/db%0d/t%0d_idle", tag, dbs[j], k),
                        {30'h0, valid_v[j], busy_v[j]}, 32'h0);
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb, rm, rw;
        logic [1:0]  rsa, rsb;
        logic [31:0] corners [5];

        vecs[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 2'b00, 2'b00, 32'h0,  32'h0, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, MIN32,        MIN32,         2'b00, 2'b00, 32'h0,  32'h0, 32'h4000_0000};
        vecs[2]  = '{3'd3, MIN32,        MIN32,         2'b00, 2'b00, 32'h0,  32'h0, 32'h4000_0000};
        vecs[3]  = '{3'd2, MIN32,        MIN32,         2'b00, 2'b00, 32'h0,  32'h0, 32'hC000_0000};
        vecs[4]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,        2'b00, 2'b00, 32'h0,  32'h0, 32'hFFFF_FFFA};
        vecs[5]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,        2'b00, 2'b00, 32'h0,  32'h0, 32'hFFFF_FFFE};
        vecs[6]  = '{3'd5, 32'd100,      32'd7,         2'b00, 2'b00, 32'h0,  32'h0, 32'd14};
        vecs[7]  = '{3'd7, 32'd100,      32'd7,         2'b00, 2'b00, 32'h0,  32'h0, 32'd2};
        vecs[8]  = '{3'd4, 32'd5,        32'd0,         2'b00, 2'b00, 32'h0,  32'h0, ONES32};
        vecs[9]  = '{3'd7, 32'd5,        32'd0,         2'b00, 2'b00, 32'h0,  32'h0, 32'd5};
        vecs[10] = '{3'd4, MIN32,        ONES32,        2'b00, 2'b00, 32'h0,  32'h0, MIN32};
        vecs[11] = '{3'd6, MIN32,        ONES32,        2'b00, 2'b00, 32'h0,  32'h0, 32'd0};
        vecs[12] = '{3'd5, 32'd99,       32'd1,         2'b01, 2'b10, 32'd12, 32'd4, 32'd3};
        vecs[13] = '{3'd5, 32'd50,       32'd5,         2'b11, 2'b00, 32'd7,  32'd9, 32'd10};
        vecs[14] = '{3'd4, 32'd7,        32'hFFFF_FFFE, 2'b00, 2'b00, 32'h0,  32'h0, 32'hFFFF_FFFD};

        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = ONES32;
        corners[3] = MIN32; corners[4] = 32'h7FFF_FFFF;

        // Reset state, with a request present to show o_busy held low.
        rst_n = 1'b0; i_valid = 1'b1; i_flush = 1'b0; i_fun3 = 3'd0;
        asel = 2'b00; bsel = 2'b00; rs1 = 32'd3; rs2 = 32'd4; mem_d = 32'h0; wb_d = 32'h0;
        #12;
        chk("reset/busy", {29'h0, busy_v}, 32'h0);
        chk("reset/valid", {29'h0, valid_v}, 32'h0);
        for (int j = 0; j < 3; j++) chk($sformatf("reset/result%0d", j), res_v[j], 32'h0);
        @(negedge clk);
        rst_n = 1'b1; i_valid = 1'b0;
        idle_cycles(1);

        // Directed table.
        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].fun3, vecs[i].rs1, vecs[i].rs2,
                   vecs[i].asel, vecs[i].bsel, vecs[i].mem, vecs[i].wb, vecs[i].exp);
        end

        // i_valid still high in DONE must not start a second operation.
        @(negedge clk);
        i_valid = 1'b1; i_fun3 = 3'd0; asel = 2'b00; bsel = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        #1;
        chk("hold/busy_accept", {29'h0, busy_v}, 32'h7);
        @(negedge clk);
        #1;
        chk("hold/done_valid", {29'h0, valid_v}, 32'h7);
        chk("hold/done_busy", {29'h0, busy_v}, 32'h0);
        chk("hold/done_result", res_v[0], 32'd15);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("hold/no_reaccept", {29'h0, valid_v}, 32'h0);

        // Flush during the 10th iteration of a divide.
        @(negedge clk);
        i_valid = 1'b1; i_fun3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7; asel = 2'b00; bsel = 2'b00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
            if (k == 10) begin
                i_flush = 1'b1;
                #1;
                chk("flush/valid_during", {30'h0, valid_v[1:0]}, 32'h0);
            end
        end
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        chk("flush/busy_after", {30'h0, busy_v[1:0]}, 32'h0);
        chk("flush/valid_after", {30'h0, valid_v[1:0]}, 32'h0);
        run_op("after_flush", 3'd0, 32'd6, 32'd9, 2'b00, 2'b00, 32'h0, 32'h0, 32'd54);

        // Reset asserted mid-divide.
        @(negedge clk);
        i_valid = 1'b1; i_fun3 = 3'd4; rs1 = 32'hFFFF_0000; rs2 = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
        rst_n = 1'b0; i_valid = 1'b1; i_fun3 = 3'd0;
        #1;
        chk("rst_mid/busy", {29'h0, busy_v}, 32'h0);
        chk("rst_mid/valid", {29'h0, valid_v}, 32'h0);
        for (int j = 0; j < 3; j++) chk($sformatf("rst_mid/result%0d", j), res_v[j], 32'h0);
        @(negedge clk);
        rst_n = 1'b1; i_valid = 1'b0;
        #1;
        chk("rst_mid/idle_valid", {29'h0, valid_v}, 32'h0);
        run_op("after_rst", 3'd0, 32'd11, 32'd13, 2'b00, 2'b00, 32'h0, 32'h0, 32'd143);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf  = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = corners[$urandom_range(0, 4)];
                1:       rb = 32'($urandom_range(0, 15));
                default: rb = 32'($urandom);
            endcase
            rm  = 32'($urandom);
            rw  = 32'($urandom);
            rsa = 2'($urandom_range(0, 3));
            rsb = 2'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d_f%0d", i, rf), rf, ra, rb, rsa, rsb, rm, rw,
                   ref_mdu(rf, ref_fwd(rsa, ra, rm, rw), ref_fwd(rsb, rb, rm, rw)));
        end

        idle_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
